digit_serial_addsub: RTL
========================

Name: digit_serial_addsub

Overview:
- Parametrised, multi-cycle adder/subtractor.
- Processes WIDTH-bit operands DIGIT bits per clock, LSB digit first, using a registered carry between digits.
- Trades latency for area; it is the sequential successor to the combinational 8-bit ripple adder/subtractor.
- Sits in the ALU datapath behind a valid/ready handshake and reports carry, signed overflow and zero flags.

Parameters:
- WIDTH, 8: operand and result width in bits. Must be a multiple of DIGIT and at least 2.
- DIGIT, 2: bits added per cycle. Must satisfy 1 <= DIGIT <= WIDTH.
- NDIG (localparam), WIDTH/DIGIT: number of digit cycles per operation.

Ports:
- Clk  input  1  clock; all state updates on the rising edge.
- Rst_n  input  1  reset, asynchronous assert, active-low.
- InValid  input  1  operands valid.
- InReady  output  1  block can accept operands.
- A  input  WIDTH  operand A.
- B  input  WIDTH  operand B.
- Sub  input  1  0 = A+B, 1 = A-B (two's complement).
- OutValid  output  1  result valid.
- OutReady  input  1  consumer accepts result.
- Sum  output  WIDTH  result.
- CarryOut  output  1  carry out of the MSB; for subtraction, 1 means no borrow (A >= B unsigned).
- Overflow  output  1  signed overflow: carry into MSB XOR carry out of MSB.
- Zero  output  1  Sum == 0.

Behaviour:
- Reset: one clock Clk; reset is asynchronous, active-low on Rst_n.
  - While Rst_n is low: state IDLE; InReady=1, OutValid=0, Sum=0, CarryOut=0, Overflow=0, Zero=0.
  - Internal operand and carry registers are cleared.
  - Reset mid-operation aborts it; no result is ever presented.
- States:
  - IDLE: InReady=1. On InValid&&InReady:
    - latch A, latch B XOR {WIDTH{Sub}}, set carry register = Sub, digit counter = 0;
    - go to BUSY.
  - BUSY: InReady=0.
    - Each cycle adds digit[cnt] of A, digit[cnt] of the masked B, and the carry register.
    - Writes the DIGIT-bit sum into Sum[cnt*DIGIT +: DIGIT] and updates the carry register.
    - On the last digit (cnt==NDIG-1), also capture the carry into the MSB bit position for overflow, register CarryOut, Overflow and Zero (Zero evaluated on the final Sum), then go to DONE.
  - DONE: OutValid=1, InReady=0.
    - Sum and flags are held stable.
    - On OutReady go to IDLE (OutValid=0 the next cycle).
- Latency: operands accepted at edge k -> OutValid high after edge k+NDIG. Throughput is one result per NDIG+2 cycles minimum.
- InValid is ignored outside IDLE. A, B and Sub are sampled only at acceptance; later changes have no effect.
- Sum, CarryOut, Overflow and Zero are undefined-free but not meaningful while OutValid=0; they hold their last values until the next DONE.
- Wrap-around: results are modulo 2^WIDTH, with no width growth.
- DIGIT==WIDTH is a legal degenerate case: one BUSY cycle.

Optional Feature:
- Macro: DIGIT_SERIAL_ADDSUB_SATURATE_EN.
- Defined: when Overflow=1, Sum is clamped to the signed maximum (0111..1) if A's MSB is 0, else to the signed minimum (1000..0). Overflow is still reported as 1, Zero is computed on the clamped value, and CarryOut is unchanged.
- Undefined: the wrapping result is presented as-is.

Decomposition:
- Package alu_pkg:
  - state enum addsub_state_t {IDLE, BUSY, DONE};
  - packed struct alu_flags_t {CarryOut, Overflow, Zero};
  - function sat_value(width, sign) helper.
- One sub-module, digit_adder: a DIGIT-bit combinational ripple slice.
  - Inputs: A, B, Cin.
  - Outputs: Sum, Cout, and the carry into the top bit, used for overflow.
  - Instantiated once and reused across cycles.

Test Plan (WIDTH=8, DIGIT=2, NDIG=4):
- Add: A=0x3C, B=0x05, Sub=0 accepted at edge k -> OutValid after edge k+4; Sum=0x41, CarryOut=0, Overflow=0, Zero=0.
- Equal subtract: A=0x05, B=0x05, Sub=1 -> Sum=0x00, CarryOut=1, Overflow=0, Zero=1.
- Signed overflow: A=0x7F, B=0x01, Sub=0 -> Overflow=1; Sum=0x80 (wrap), or 0x7F with SATURATE_EN; CarryOut=0.
- Borrow: A=0x00, B=0x01, Sub=1 -> Sum=0xFF, CarryOut=0, Overflow=0, Zero=0. Also A=0x80, B=0x01, Sub=1 -> Sum=0x7F (0x80 with SATURATE_EN), Overflow=1.
- Backpressure: hold OutReady=0 for 3 cycles in DONE while driving InValid=1 with new operands -> Sum and flags stable, InReady=0, new operands not taken. Raise OutReady -> IDLE next cycle, then the new operands are accepted.
- Reset mid-BUSY: drop Rst_n at cnt=2 -> outputs zero immediately with no clock, OutValid never asserts. After release, InReady=1 and a fresh 0x10+0x20 gives 0x30.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared ALU types: add/sub FSM states, flag bundle, saturation helper.
// Used by digit_serial_addsub and its digit_adder slice.
package alu_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } addsub_state_t;

  typedef struct packed {
    logic carry_out;
    logic overflow;
    logic zero;
  } alu_flags_t;

  function automatic logic [63:0] sat_value(
    input int   width,
    input logic sign
  );
    logic [63:0] min_v;
    min_v = 64'd1 << (width - 1);
    return sign ? min_v : (min_v - 64'd1);
  endfunction

endpackage

// File: rtl/digit_adder.sv
// DIGIT-bit combinational ripple slice.
// Also exposes the carry into its top bit for overflow detection.
module digit_adder
  import alu_pkg::*;
#(
  parameter int DIGIT = 2
) (
  input  logic [DIGIT-1:0] A,
  input  logic [DIGIT-1:0] B,
  input  logic             Cin,
  output logic [DIGIT-1:0] Sum,
  output logic             Cout,
  output logic             CarryTop
);

  logic [DIGIT:0] c;

  // Bitwise ripple through the slice
  always_comb begin
    c    = '0;
    Sum  = '0;
    c[0] = Cin;
    for (int i = 0; i < DIGIT; i++) begin
      Sum[i]   = A[i] ^ B[i] ^ c[i];
      c[i+1]   = (A[i] & B[i]) | (c[i] & (A[i] ^ B[i]));
    end
  end

  assign Cout     = c[DIGIT];
  assign CarryTop = c[DIGIT-1];

endmodule

// File: rtl/digit_serial_addsub.sv
// Digit-serial adder/subtractor, LSB digit first, valid/ready in and out.
// Optional clamp on signed overflow: DIGIT_SERIAL_ADDSUB_SATURATE_EN.
module digit_serial_addsub
  import alu_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DIGIT = 2
) (
  input  logic             Clk,
  input  logic             Rst_n,
  input  logic             InValid,
  output logic             InReady,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Sub,
  output logic             OutValid,
  input  logic             OutReady,
  output logic [WIDTH-1:0] Sum,
  output logic             CarryOut,
  output logic             Overflow,
  output logic             Zero
);

  localparam int NDIG = WIDTH / DIGIT;
  localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;

  addsub_state_t    state;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic             c_q;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] sum_q;
  alu_flags_t       flags_q;

  logic [DIGIT-1:0] a_d;
  logic [DIGIT-1:0] b_d;
  logic [DIGIT-1:0] s_d;
  logic             co_d;
  logic             ct_d;
  logic             last;
  logic             ovf;
  logic [WIDTH-1:0] next_sum;
  logic [WIDTH-1:0] final_sum;

  assign last = (cnt == CW'(NDIG - 1));
  assign ovf  = co_d ^ ct_d;

  // Select the current digit of both operands
  always_comb begin
    a_d = a_q[int'(cnt)*DIGIT +: DIGIT];
    b_d = b_q[int'(cnt)*DIGIT +: DIGIT];
  end

  digit_adder #(
    .DIGIT(DIGIT)
  ) u_slice (
    .A       (a_d),
    .B       (b_d),
    .Cin     (c_q),
    .Sum     (s_d),
    .Cout    (co_d),
    .CarryTop(ct_d)
  );

  // Merge the new digit into the partial result; clamp on the last digit
  always_comb begin
    next_sum = sum_q;
    next_sum[int'(cnt)*DIGIT +: DIGIT] = s_d;
`ifdef DIGIT_SERIAL_ADDSUB_SATURATE_EN
    if (ovf)
      final_sum = WIDTH'(sat_value(WIDTH, a_q[WIDTH-1]));
    else
      final_sum = next_sum;
`else
    final_sum = next_sum;
`endif
  end

  // FSM, operand latching, digit sequencing and flag capture
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state   <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      c_q     <= 1'b0;
      cnt     <= '0;
      sum_q   <= '0;
      flags_q <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (InValid) begin
            a_q   <= A;
            b_q   <= B ^ {WIDTH{Sub}};
            c_q   <= Sub;
            cnt   <= '0;
            state <= BUSY;
          end
        end
        BUSY: begin
          c_q <= co_d;
          if (last) begin
            sum_q             <= final_sum;
            flags_q.carry_out <= co_d;
            flags_q.overflow  <= ovf;
            flags_q.zero      <= (final_sum == '0);
            state             <= DONE;
          end else begin
            sum_q <= next_sum;
            cnt   <= cnt + 1'b1;
          end
        end
        DONE: begin
          if (OutReady)
            state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign InReady  = (state == IDLE);
  assign OutValid = (state == DONE);
  assign Sum      = sum_q;
  assign CarryOut = flags_q.carry_out;
  assign Overflow = flags_q.overflow;
  assign Zero     = flags_q.zero;

endmodule
